lfsr_stream_ctrl: RTL and testbench

Command-driven sequencer for the 8-bit Fibonacci LFSR datapath (taps 8,6,5,4; next = {q[6:0], q[7]^q[5]^q[4]^q[3]}).
- Accepts a seed and a burst length over a valid/ready command port.
- Streams the requested number of pseudo-random bytes over a valid/ready output port with backpressure, supports abort, and reports a completion pulse and a final signature.
- Sits between the top-level pin logic and the LFSR register.

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr8_core.sv | 29 ++
 rtl/lfsr_stream_ctrl.sv | 114 +++++++++++
 tb/tb_lfsr_stream_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the 8-bit Fibonacci LFSR stream controller.
package lfsr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } state_e;

  // Taps 8,6,5,4 expressed as bit positions 7,5,4,3 of the state register.
  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] ZERO_SEED_SUB_DEF = 8'h01;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8_core.sv
// 8-bit Fibonacci LFSR register with seed load and single-step enables.
module lfsr8_core
  import lfsr_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = ZERO_SEED_SUB_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] q,
  output logic [7:0] q_next
);

  assign q_next = lfsr8_next(q);

  // Load wins over step; the controller never asserts both.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/lfsr_stream_ctrl.sv
// Command-driven burst sequencer streaming LFSR bytes over valid/ready with abort.
module lfsr_stream_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned LEN_W         = 8,
  parameter logic [7:0]  ZERO_SEED_SUB = ZERO_SEED_SUB_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_seed,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [7:0]       sig
);

  // One extra counter bit lets a zero length mean a full 2^LEN_W burst.
  localparam logic [LEN_W:0] CntOne  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] CntFull = {1'b1, {LEN_W{1'b0}}};

  state_e           state_q, state_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic [7:0]       sig_q, sig_d;
  logic             aborted_q, aborted_d;
  logic             lfsr_load, lfsr_step;
  logic [7:0]       lfsr_seed, lfsr_q, lfsr_next;
  logic             hs;

  lfsr8_core #(
    .RESET_VAL (ZERO_SEED_SUB)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .step   (lfsr_step),
    .seed   (lfsr_seed),
    .q      (lfsr_q),
    .q_next (lfsr_next)
  );

  assign lfsr_seed = (cmd_seed == 8'h00) ? ZERO_SEED_SUB : cmd_seed;
  assign cmd_ready = (state_q == StIdle);
  assign out_valid = (state_q == StStream);
  assign out_data  = lfsr_q;
  assign out_last  = out_valid && (cnt_q == CntOne);
  assign busy      = (state_q == StStream) || (state_q == StDone);
  assign done      = (state_q == StDone);
  assign aborted   = aborted_q;
  assign sig       = sig_q;
  assign hs        = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    aborted_d = aborted_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          lfsr_load = 1'b1;
          cnt_d     = (cmd_len == '0) ? CntFull : {1'b0, cmd_len};
          aborted_d = 1'b0;
          state_d   = StStream;
        end
      end
      StStream: begin
        lfsr_step = hs;
        if (hs) begin
          cnt_d = cnt_q - CntOne;
        end
        // A byte handshaken alongside abort still counts toward the signature.
        if (abort) begin
          sig_d     = hs ? lfsr_next : lfsr_q;
          aborted_d = 1'b1;
          state_d   = StDone;
        end else if (hs && out_last) begin
          sig_d   = lfsr_next;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sig_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sig_q     <= sig_d;
      aborted_q <= aborted_d;
    end
  end

endmodule

// File: tb/tb_lfsr_stream_ctrl.sv
// Directed bench for lfsr_stream_ctrl with hand-computed byte sequences and signatures.
module tb_lfsr_stream_ctrl;

  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_seed;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [7:0]       sig;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfsr_stream_ctrl #(
    .LEN_W         (LEN_W),
    .ZERO_SEED_SUB (8'h01)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_seed  (cmd_seed),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .sig       (sig)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] seed, input logic [LEN_W-1:0] len);
    chk("cmd_ready_idle", 16'(cmd_ready), 16'h1);
    cmd_valid = 1'b1;
    cmd_seed  = seed;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] d, input logic last);
    chk({tag, "_valid"}, 16'(out_valid), 16'h1);
    chk({tag, "_data"},  16'(out_data),  16'(d));
    chk({tag, "_last"},  16'(out_last),  16'(last));
  endtask

  task automatic expect_done(input string tag, input logic [7:0] s, input logic ab);
    chk({tag, "_done"},    16'(done),      16'h1);
    chk({tag, "_busy"},    16'(busy),      16'h1);
    chk({tag, "_vld_low"}, 16'(out_valid), 16'h0);
    chk({tag, "_rdy_low"}, 16'(cmd_ready), 16'h0);
    chk({tag, "_sig"},     16'(sig),       16'(s));
    chk({tag, "_aborted"}, 16'(aborted),   16'(ab));
    tick();
    chk({tag, "_done_drop"}, 16'(done),      16'h0);
    chk({tag, "_idle_rdy"},  16'(cmd_ready), 16'h1);
    chk({tag, "_sig_hold"},  16'(sig),       16'(s));
    chk({tag, "_ab_hold"},   16'(aborted),   16'(ab));
  endtask

  logic [7:0] seq5 [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
  logic [7:0] v;
  int         hs_cnt;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_seed  = 8'h00;
    cmd_len   = '0;
    abort     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cmd_ready", 16'(cmd_ready), 16'h1);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_last",  16'(out_last),  16'h0);
    chk("rst_busy",      16'(busy),      16'h0);
    chk("rst_done",      16'(done),      16'h0);
    chk("rst_aborted",   16'(aborted),   16'h0);
    chk("rst_sig",       16'(sig),       16'h0);

    // Seed 01, len 5, no backpressure.
    start(8'h01, 8'd5);
    for (int i = 0; i < 5; i++) begin
      expect_byte("t1", seq5[i], i == 4);
      tick();
    end
    expect_done("t1", 8'h23, 1'b0);

    // Zero seed replaced by 01.
    start(8'h00, 8'd2);
    expect_byte("t2b0", 8'h01, 1'b0);
    tick();
    expect_byte("t2b1", 8'h02, 1'b1);
    tick();
    expect_done("t2", 8'h04, 1'b0);

    // Backpressure holds data stable.
    start(8'h01, 8'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_byte("t3hold", 8'h01, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    hs_cnt = 0;
    expect_byte("t3b0", 8'h01, 1'b0);
    hs_cnt += int'(out_valid);
    tick();
    expect_byte("t3b1", 8'h02, 1'b0);
    hs_cnt += int'(out_valid);
    tick();
    expect_byte("t3b2", 8'h04, 1'b1);
    hs_cnt += int'(out_valid);
    tick();
    chk("t3_hs_count", 16'(hs_cnt), 16'd3);
    expect_done("t3", 8'h08, 1'b0);

    // len 0 means 256 bytes; period 255 brings byte 256 back to 01.
    start(8'h01, 8'd0);
    v = 8'h01;
    for (int i = 0; i < 256; i++) begin
      expect_byte("t4", v, i == 255);
      if (i == 255) chk("t4_byte256", 16'(out_data), 16'h01);
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      tick();
    end
    expect_done("t4", 8'h02, 1'b0);

    // Abort together with the handshake of the third byte.
    start(8'h01, 8'd10);
    expect_byte("t5b0", 8'h01, 1'b0);
    tick();
    expect_byte("t5b1", 8'h02, 1'b0);
    tick();
    expect_byte("t5b2", 8'h04, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_done("t5", 8'h08, 1'b1);
    chk("t5_abort_ignored_idle", 16'(cmd_ready), 16'h1);

    // Reset mid-burst discards it without a done pulse.
    start(8'h01, 8'd5);
    expect_byte("t6b0", 8'h01, 1'b0);
    tick();
    expect_byte("t6b1", 8'h02, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_out_valid", 16'(out_valid), 16'h0);
    chk("t6_cmd_ready", 16'(cmd_ready), 16'h1);
    chk("t6_sig",       16'(sig),       16'h0);
    chk("t6_done",      16'(done),      16'h0);
    chk("t6_aborted",   16'(aborted),   16'h0);
    tick();
    chk("t6_no_done", 16'(done), 16'h0);
    start(8'h01, 8'd5);
    for (int i = 0; i < 5; i++) begin
      expect_byte("t6r", seq5[i], i == 4);
      tick();
    end
    expect_done("t6r", 8'h23, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
